// File: rtl/host_cmd_master.sv
// Host-side command initiator: serializes register/ALU commands into UART frame
// bytes and collects response bytes from the receiver under an inactivity timeout.
module host_cmd_master #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUNC_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_A,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_B,
    input  logic [FUNC_WIDTH-1:0]   CMD_FUNC,
    output logic [DATA_WIDTH-1:0]   TX_BYTE,
    output logic                    TX_BYTE_VALID,
    input  logic                    TX_BYTE_READY,
    input  logic [DATA_WIDTH-1:0]   RX_BYTE,
    input  logic                    RX_BYTE_VALID,
    output logic                    RSP_VALID,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_TIMEOUT,
    output logic                    STRAY_BYTE
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    state_t                  state, state_d;
    logic [1:0]              type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [FUNC_WIDTH-1:0]   func_q, func_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              rsp_cnt_q, rsp_cnt_d;
    logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_byte_q, rx_byte_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]   tx_byte_d;
    logic                    tx_valid_d, rsp_valid_d, rsp_timeout_d, stray_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_d;

    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]            t,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [FUNC_WIDTH-1:0] f,
        input logic [1:0]            idx
    );
        logic [DATA_WIDTH-1:0] addr_x;
        logic [DATA_WIDTH-1:0] func_x;
        addr_x = DATA_WIDTH'(addr);
        func_x = DATA_WIDTH'(f);
        case (t)
            2'd0: case (idx)
                2'd0:    frame_byte = DATA_WIDTH'(8'hAA);
                2'd1:    frame_byte = addr_x;
                default: frame_byte = a;
            endcase
            2'd1: frame_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : addr_x;
            2'd2: case (idx)
                2'd0:    frame_byte = DATA_WIDTH'(8'hCC);
                2'd1:    frame_byte = a;
                2'd2:    frame_byte = b;
                default: frame_byte = func_x;
            endcase
            default: frame_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : func_x;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] t);
        case (t)
            2'd0:    last_idx = 2'd2;
            2'd2:    last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(input logic [1:0] t);
        case (t)
            2'd0:    rsp_len = 2'd0;
            2'd1:    rsp_len = 2'd1;
            default: rsp_len = 2'd2;
        endcase
    endfunction

    assign CMD_READY = (state == IDLE);

    always_comb begin
        state_d       = state;
        type_d        = type_q;
        addr_d        = addr_q;
        a_d           = a_q;
        b_d           = b_q;
        func_d        = func_q;
        idx_d         = idx_q;
        rsp_cnt_d     = rsp_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        tx_byte_d     = TX_BYTE;
        tx_valid_d    = TX_BYTE_VALID;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = RSP_DATA;
        // RX is staged one cycle; the raw strobe still restarts the timeout immediately.
        rx_byte_d     = RX_BYTE;
        rx_valid_d    = RX_BYTE_VALID && (state == WAIT_RSP);
        stray_d       = RX_BYTE_VALID && (state != WAIT_RSP);

        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    type_d     = CMD_TYPE;
                    addr_d     = CMD_ADDR;
                    a_d        = CMD_DATA_A;
                    b_d        = CMD_DATA_B;
                    func_d     = CMD_FUNC;
                    idx_d      = '0;
                    rsp_cnt_d  = '0;
                    rsp_data_d = '0;
                    tx_byte_d  = frame_byte(CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUNC, 2'd0);
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (TX_BYTE_READY) begin
                    if (idx_q == last_idx(type_q)) begin
                        tx_valid_d = 1'b0;
                        tx_byte_d  = '0;
                        wait_cnt_d = '0;
                        if (type_q == 2'd0) begin
                            state_d     = DONE;
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d = WAIT_RSP;
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_byte_d = frame_byte(type_q, addr_q, a_q, b_q, func_q, idx_q + 2'd1);
                    end
                end
            end
            WAIT_RSP: begin
                if (RX_BYTE_VALID) wait_cnt_d = CW'(1);
                else               wait_cnt_d = wait_cnt_q + CW'(1);
                if (rx_valid_q) begin
                    if (rsp_cnt_q[0]) rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_byte_q;
                    else              rsp_data_d[DATA_WIDTH-1:0]            = rx_byte_q;
                    rsp_cnt_d = rsp_cnt_q + 2'd1;
                end
                if (rx_valid_q && (rsp_cnt_q + 2'd1 == rsp_len(type_q))) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end else if (!RX_BYTE_VALID && (wait_cnt_q == LIMIT)) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            type_q        <= '0;
            addr_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            func_q        <= '0;
            idx_q         <= '0;
            rsp_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            TX_BYTE       <= '0;
            TX_BYTE_VALID <= 1'b0;
            RSP_VALID     <= 1'b0;
            RSP_DATA      <= '0;
            RSP_TIMEOUT   <= 1'b0;
            STRAY_BYTE    <= 1'b0;
        end else begin
            state         <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            func_q        <= func_d;
            idx_q         <= idx_d;
            rsp_cnt_q     <= rsp_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            TX_BYTE       <= tx_byte_d;
            TX_BYTE_VALID <= tx_valid_d;
            RSP_VALID     <= rsp_valid_d;
            RSP_DATA      <= rsp_data_d;
            RSP_TIMEOUT   <= rsp_timeout_d;
            STRAY_BYTE    <= stray_d;
        end
    end

endmodule

// File: tb/tb_host_cmd_master.sv
// Randomized self-checking bench for host_cmd_master against a frame/response model.
module tb_host_cmd_master;
    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_data_a = '0;
    logic [7:0]  cmd_data_b = '0;
    logic [3:0]  cmd_func = '0;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_valid = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        stray_byte;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    host_cmd_master #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .FUNC_WIDTH(4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .CMD_VALID(cmd_valid),
        .CMD_READY(cmd_ready),
        .CMD_TYPE(cmd_type),
        .CMD_ADDR(cmd_addr),
        .CMD_DATA_A(cmd_data_a),
        .CMD_DATA_B(cmd_data_b),
        .CMD_FUNC(cmd_func),
        .TX_BYTE(tx_byte),
        .TX_BYTE_VALID(tx_byte_valid),
        .TX_BYTE_READY(tx_byte_ready),
        .RX_BYTE(rx_byte),
        .RX_BYTE_VALID(rx_byte_valid),
        .RSP_VALID(rsp_valid),
        .RSP_DATA(rsp_data),
        .RSP_TIMEOUT(rsp_timeout),
        .STRAY_BYTE(stray_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   cmd_ready, 1);
        check({tag, "_txv"},     tx_byte_valid, 0);
        check({tag, "_txb"},     tx_byte, 0);
        check({tag, "_rspv"},    rsp_valid, 0);
        check({tag, "_rspd"},    rsp_data, 0);
        check({tag, "_timeout"}, rsp_timeout, 0);
        check({tag, "_stray"},   stray_byte, 0);
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = toggle starting at 1
    task automatic run_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] f, input int ready_mode,
                           input int nrx, input logic [7:0] rx0, input logic [7:0] rx1,
                           input bit last_at_limit);
        logic [7:0]  frame[$];
        logic [15:0] exp_data;
        logic [7:0]  rxv;
        int need, n, k, stalls, ev, due, g, target;
        bit rdy;
        case (t)
            2'd0:    frame = '{8'hAA, {4'h0, addr}, a};
            2'd1:    frame = '{8'hBB, {4'h0, addr}};
            2'd2:    frame = '{8'hCC, a, b, {4'h0, f}};
            default: frame = '{8'hDD, {4'h0, f}};
        endcase
        need = (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
        n = (nrx > need) ? need : nrx;

        check("ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_type   = t;
        cmd_addr   = addr;
        cmd_data_a = a;
        cmd_data_b = b;
        cmd_func   = f;
        step();
        cmd_valid  = 1'b0;
        cmd_type   = 2'($urandom);
        cmd_addr   = 4'($urandom);
        cmd_data_a = 8'($urandom);
        cmd_data_b = 8'($urandom);
        cmd_func   = 4'($urandom);

        k = 0;
        stalls = 0;
        rdy = 1'b0;
        while (k < frame.size()) begin
            check("tx_valid", tx_byte_valid, 1);
            check("tx_byte", tx_byte, frame[k]);
            check("ready_busy", cmd_ready, 0);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(1, 0));
                default: rdy = ~rdy;
            endcase
            if (stalls >= 8) rdy = 1'b1;
            tx_byte_ready = rdy;
            step();
            if (rdy) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
        end
        tx_byte_ready = 1'($urandom_range(1, 0));
        check("tx_valid_end", tx_byte_valid, 0);

        exp_data = '0;
        if (need != 0) begin
            ev = cyc;
            for (int i = 0; i < n; i++) begin
                if (last_at_limit && i == n - 1) g = T - 1;
                else if (i == 0)                 g = $urandom_range(T - 1, 0);
                else                             g = $urandom_range(T - 1, 1);
                target = ev + g;
                while (cyc < target) begin
                    check("rsp_early", rsp_valid, 0);
                    step();
                end
                rxv = (i == 0) ? rx0 : rx1;
                rx_byte = rxv;
                rx_byte_valid = 1'b1;
                exp_data[8*i +: 8] = rxv;
                ev = cyc;
                step();
                rx_byte_valid = 1'b0;
                rx_byte = 8'($urandom);
            end
            due = (n == need) ? ev + 2 : ev + int'(T);
            while (cyc < due) begin
                check("rsp_early", rsp_valid, 0);
                check("stray_wait", stray_byte, 0);
                step();
            end
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_timeout", rsp_timeout, (n < need) ? 1 : 0);
        step();
        check("rsp_pulse", rsp_valid, 0);
        check("ready_back", cmd_ready, 1);
    endtask

    task automatic stray_in_idle();
        rx_byte = 8'($urandom);
        rx_byte_valid = 1'b1;
        step();
        rx_byte_valid = 1'b0;
        check("stray_pulse", stray_byte, 1);
        check("stray_ready", cmd_ready, 1);
        check("stray_txv", tx_byte_valid, 0);
        check("stray_rspv", rsp_valid, 0);
        step();
        check("stray_clear", stray_byte, 0);
        check("stray_ready2", cmd_ready, 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("post_reset");

        // directed scenarios
        run_cmd(2'd0, 4'h3, 8'h05, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 1'b0);
        run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 2, 1, 8'h81, 8'h00, 1'b0);
        run_cmd(2'd2, 4'h0, 8'h10, 8'h20, 4'h2, 0, 2, 8'h00, 8'h02, 1'b0);
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 0, 1, 8'h30, 8'h00, 1'b0);
        run_cmd(2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 0, 1, 8'h5A, 8'h00, 1'b1);
        run_cmd(2'd2, 4'h0, 8'hFF, 8'h01, 4'hF, 1, 2, 8'h34, 8'h12, 1'b1);
        run_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 1'b0);
        stray_in_idle();

        // reset in the middle of a frame
        cmd_valid  = 1'b1;
        cmd_type   = 2'd2;
        cmd_data_a = 8'h11;
        cmd_data_b = 8'h22;
        cmd_func   = 4'h3;
        step();
        cmd_valid = 1'b0;
        check("mid_b0", tx_byte, 8'hCC);
        tx_byte_ready = 1'b1;
        step();
        tx_byte_ready = 1'b0;
        check("mid_b1", tx_byte, 8'h11);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_rst_ready", cmd_ready, 1);
            check("after_rst_rspv", rsp_valid, 0);
            check("after_rst_txv", tx_byte_valid, 0);
        end
        run_cmd(2'd2, 4'h0, 8'h11, 8'h22, 4'h3, 0, 2, 8'hA5, 8'h5A, 1'b0);

        // randomized commands
        for (int r = 0; r < 40; r++) begin
            logic [1:0] t;
            int n;
            t = 2'($urandom_range(3, 0));
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(1, 0)) : 2;
            if ($urandom_range(3, 0) == 0) stray_in_idle();
            repeat ($urandom_range(2, 0)) step();
            run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                    int'($urandom_range(1, 0)), n, 8'($urandom), 8'($urandom),
                    $urandom_range(7, 0) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
